// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, constants and helpers for the timer controller
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } timer_state_t;

    localparam int DIGIT_W = 4;

    // Largest value a digit of the given modulus can hold.
    function automatic logic [DIGIT_W-1:0] digit_max(input int digit_mod);
        return DIGIT_W'(digit_mod - 1);
    endfunction

endpackage

// File: rtl/timer_digit.sv
// rtl/timer_digit.sv - one mod-DIGIT_MOD up/down digit of the timer cascade
module timer_digit
    import timer_pkg::*;
#(
    parameter int DIGIT_MOD = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               inc,
    input  logic               down,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] nxt,
    output logic               tc
);

    localparam logic [DIGIT_W-1:0] MAX = digit_max(DIGIT_MOD);

    // Terminal count is the value that rolls over on the next step in the current direction.
    assign tc = down ? (value == '0) : (value == MAX);

    // Value this digit will hold after the coming edge; exported so the alarm compare sees it early.
    always_comb begin
        nxt = value;
        if (inc) begin
            if (down) begin
                nxt = tc ? MAX : value - DIGIT_W'(1);
            end else begin
                nxt = tc ? '0 : value + DIGIT_W'(1);
            end
        end
    end

    // Digit register; clear wins over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            value <= '0;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - run/pause/clear stopwatch controller with prescaler, digit cascade and alarm (optional TIMER_CTRL_DOWN_EN adds dir)
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_MOD  = 10,
    parameter int PRESCALE   = 100
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          clear,
`ifdef TIMER_CTRL_DOWN_EN
    input  logic                          dir,
`endif
    input  logic                          alarm_en,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] alarm_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          running,
    output logic                          tick,
    output logic                          wrap,
    output logic                          alarm
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    timer_state_t                  state;
    logic [PW-1:0]                 presc;
    logic [NUM_DIGITS-1:0]         tc;
    logic [NUM_DIGITS-1:0]         en;
    logic [DIGIT_W*NUM_DIGITS-1:0] nxt;
    logic                          cnt_down;
    logic                          all_tc;
    logic                          hit;

`ifdef TIMER_CTRL_DOWN_EN
    assign cnt_down = dir;
`else
    assign cnt_down = 1'b0;
`endif

    assign tick    = (state == ST_RUN) && (presc == PRE_LAST);
    assign all_tc  = &tc;
    // Next digits are always in range, so an out-of-range alarm value can never match.
    assign hit     = tick && alarm_en && (nxt == alarm_val);
    assign running = (state == ST_RUN);
    assign alarm   = (state == ST_ALARM);

    // Ripple-carry enable chain: a digit steps when the tick reaches it through all rolling-over lower digits.
    always_comb begin
        en    = '0;
        en[0] = tick;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            en[i] = en[i-1] & tc[i-1];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        timer_digit #(
            .DIGIT_MOD (DIGIT_MOD)
        ) u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clear),
            .inc     (en[g]),
            .down    (cnt_down),
            .value   (digits[g*DIGIT_W +: DIGIT_W]),
            .nxt     (nxt[g*DIGIT_W +: DIGIT_W]),
            .tc      (tc[g])
        );
    end

    // Control FSM, prescaler and wrap pulse; clear > stop > start, alarm hit beats stop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                state <= ST_IDLE;
                presc <= '0;
            end else begin
                if (tick) begin
                    wrap <= all_tc;
                end
                case (state)
                    ST_RUN: begin
                        // A pending tick always completes; otherwise stopping freezes the phase.
                        if (tick) begin
                            presc <= '0;
                        end else if (!stop) begin
                            presc <= presc + PW'(1);
                        end
                        if (hit) begin
                            state <= ST_ALARM;
                        end else if (stop) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_IDLE, ST_PAUSE, ST_ALARM: begin
                        if (start && !stop) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl against a counting reference model
module tb_timer_ctrl;

    localparam int ND  = 2;
    localparam int MOD = 10;
    localparam int PRE = 4;
    localparam int TOP = 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       dir = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] alarm_val = 8'h00;
    logic [7:0] digits;
    logic       running;
    logic       tick;
    logic       wrap;
    logic       alarm;

    always #5 clk = ~clk;

    timer_ctrl #(
        .NUM_DIGITS (ND),
        .DIGIT_MOD  (MOD),
        .PRESCALE   (PRE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
`ifdef TIMER_CTRL_DOWN_EN
        .dir       (dir),
`endif
        .alarm_en  (alarm_en),
        .alarm_val (alarm_val),
        .digits    (digits),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap),
        .alarm     (alarm)
    );

    typedef struct {
        logic [7:0] d;
        logic       r;
        logic       a;
        logic       w;
        logic       t;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop = 0;

    int   m_mode = M_IDLE;
    int   m_pre = 0;
    int   m_cnt = 0;
    bit   m_wrap = 0;

    function automatic logic [7:0] pack(input int c);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(c / 10);
        lo = 4'(c % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the whole display is one integer modulo 100.
    task automatic model_update();
        bit tk;
        bit hit;
        int ncnt;
        if (!reset_n) begin
            m_mode = M_IDLE;
            m_pre  = 0;
            m_cnt  = 0;
            m_wrap = 0;
        end else begin
            tk     = (m_mode == M_RUN) && (m_pre == PRE - 1);
            m_wrap = 0;
            hit    = 0;
            if (clear) begin
                m_mode = M_IDLE;
                m_pre  = 0;
                m_cnt  = 0;
            end else begin
                if (tk) begin
                    if (dir) begin
                        ncnt   = (m_cnt + TOP - 1) % TOP;
                        m_wrap = (m_cnt == 0);
                    end else begin
                        ncnt   = (m_cnt + 1) % TOP;
                        m_wrap = (m_cnt == TOP - 1);
                    end
                    m_cnt = ncnt;
                    hit   = alarm_en && (pack(ncnt) == alarm_val);
                end
                if (m_mode == M_RUN) begin
                    if (tk) m_pre = 0;
                    else if (!stop) m_pre = m_pre + 1;
                    if (hit) m_mode = M_ALARM;
                    else if (stop) m_mode = M_PAUSE;
                end else if (start && !stop) begin
                    m_mode = M_RUN;
                end
            end
        end
    endtask

    // One clock: inputs already driven are sampled at this edge, expectation queued for the monitor.
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_update();
        e.d = pack(m_cnt);
        e.r = (m_mode == M_RUN);
        e.a = (m_mode == M_ALARM);
        e.w = m_wrap;
        e.t = (m_mode == M_RUN) && (m_pre == PRE - 1);
        q.push_back(e);
        n_push++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares every queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_pop++;
            chk("sb_digits", 32'(digits), 32'(e.d));
            chk("sb_running", 32'(running), 32'(e.r));
            chk("sb_alarm", 32'(alarm), 32'(e.a));
            chk("sb_wrap", 32'(wrap), 32'(e.w));
            chk("sb_tick", 32'(tick), 32'(e.t));
        end
    end

    initial begin
        int c0;
        logic [7:0] d0;

        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;
        step();
        chk("reset_digits", 32'(digits), 32'h00);
        chk("reset_running", 32'(running), 32'h0);
        chk("reset_tick", 32'(tick), 32'h0);

        start = 1'b1; step(); start = 1'b0;
        run(40);
        chk("run40_digits", 32'(digits), 32'h10);
        chk("run40_running", 32'(running), 32'h1);

        run(356);
        chk("at99_digits", 32'(digits), 32'h99);
        run(4);
        chk("wrap_digits", 32'(digits), 32'h00);
        chk("wrap_pulse", 32'(wrap), 32'h1);
        step();
        chk("wrap_end", 32'(wrap), 32'h0);

        clear = 1'b1; step(); clear = 1'b0;
        alarm_en = 1'b1; alarm_val = 8'h05;
        start = 1'b1; step(); start = 1'b0;
        run(20);
        chk("alarm_hit", 32'(alarm), 32'h1);
        chk("alarm_digits", 32'(digits), 32'h05);
        chk("alarm_norun", 32'(running), 32'h0);
        run(20);
        chk("alarm_hold", 32'(digits), 32'h05);
        start = 1'b1; step(); start = 1'b0;
        run(4);
        chk("resume_digits", 32'(digits), 32'h06);
        chk("resume_alarm", 32'(alarm), 32'h0);

        alarm_en = 1'b0;
        for (int k = 0; k < 8 && m_pre != 2; k++) step();
        c0 = m_cnt;
        stop = 1'b1; step(); stop = 1'b0;
        d0 = digits;
        run(10);
        chk("pause_hold", 32'(digits), 32'(d0));
        chk("pause_norun", 32'(running), 32'h0);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("resume_tick", 32'(tick), 32'h1);
        step();
        chk("resume_inc", 32'(digits), 32'(pack((c0 + 1) % TOP)));

        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        run(148);
        chk("at37_digits", 32'(digits), 32'h37);
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        chk("clr_start_digits", 32'(digits), 32'h00);
        chk("clr_start_running", 32'(running), 32'h0);
        start = 1'b1; step(); start = 1'b0;
        run(9);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("midrun_reset_digits", 32'(digits), 32'h00);
        chk("midrun_reset_running", 32'(running), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 23) == 0);
            clear   = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 49) == 0) alarm_en = 1'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 3) == 0) alarm_val = 8'($urandom);
                else alarm_val = pack(int'($urandom_range(0, TOP - 1)));
            end
`ifdef TIMER_CTRL_DOWN_EN
            if ($urandom_range(0, 99) == 0) dir = 1'($urandom);
`endif
            step();
        end

        reset_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'h0);
        chk("sb_count", 32'(n_pop), 32'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Run/pause/clear controller and scheduler for a cascade of mod-DIGIT_MOD digit counters. Forms a prescaled stopwatch/timer.
- Generates the prescaled tick and sequences each digit's increment enable (ripple carry). Detects a programmable alarm value.
- Sits between control/button logic and display drivers in timer designs.

Parameters:
- NUM_DIGITS, 4, number of cascaded digits (1..8)
- DIGIT_MOD, 10, modulus of each digit (2..16); digit counts 0..DIGIT_MOD-1
- PRESCALE, 100, clk cycles per tick (>=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  level/pulse; enter RUN
- stop  input  1  level/pulse; RUN -> PAUSE
- clear  input  1  zero digits and prescaler, go IDLE
- alarm_en  input  1  enable alarm compare
- alarm_val  input  4*NUM_DIGITS  alarm value, digit i at bits [4i+3:4i]
- digits  output  4*NUM_DIGITS  current digit values, same packing
- running  output  1  high in RUN
- tick  output  1  combinational; high when a digit update occurs this cycle
- wrap  output  1  one-cycle registered pulse after full-cascade wrap
- alarm  output  1  high while in ALARM

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, prescaler 0, digits 0, wrap 0. Consequently running=0, alarm=0, tick=0. Reset overrides all inputs.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE; alarm hit -> ALARM.
  - PAUSE: start -> RUN.
  - ALARM: start -> RUN.
  - Any state: clear -> IDLE.
- Command priority per edge: clear > stop > start. start and stop together in RUN -> PAUSE; in IDLE or PAUSE they cause no transition.
- Clear: digits 0, prescaler 0, wrap 0 at that edge.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN and wraps to 0.
  - Holds its value in PAUSE and ALARM; is 0 in IDLE.
  - tick = (state==RUN) && (prescaler==PRESCALE-1).
- Latency: the edge sampling start enters RUN. The prescaler advances from the following edge. The first digit update is on the PRESCALE-th edge after the start-sampling edge when starting from IDLE.
- Cascade:
  - Digit 0 increments on tick.
  - Digit i increments on tick when all digits j<i equal DIGIT_MOD-1.
  - A digit at DIGIT_MOD-1 that increments goes to 0.
  - All digits at max plus tick -> all 0, and wrap=1 for exactly the next cycle.
- Alarm:
  - Compare uses next-state digits on tick edges only.
  - If alarm_en and the next digits equal alarm_val, then at that edge the digits take the value, state goes to ALARM, and counting freezes.
  - An alarm_val outside the digit range never matches.
  - Resuming (start) from ALARM does not re-trigger until a future tick produces equality again.
- Out-of-range digits cannot occur. Outputs change only on clk edges, except tick.

Optional Feature:
- Macro TIMER_CTRL_DOWN_EN.
- When defined: adds an input port dir (1 bit).
  - dir=1 counts down: digit i decrements on tick when all lower digits equal 0; 0 decrements to DIGIT_MOD-1.
  - All zero plus tick -> all DIGIT_MOD-1, with a wrap pulse.
  - dir is sampled every tick and may change while running.
  - The alarm compare applies identically.
- When undefined: no dir port; up-count only.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, ALARM)
  - localparam DIGIT_W=4
  - function for digit max (DIGIT_MOD-1)
- One natural sub-module, timer_digit:
  - single mod-DIGIT_MOD digit with inc, clr, (dir), value, and terminal-count output.
  - Instantiated NUM_DIGITS times via generate; timer_ctrl owns the FSM, prescaler, enable chain and alarm.

Test Plan (NUM_DIGITS=2, DIGIT_MOD=10, PRESCALE=4):
- Reset held 3 cycles, then released -> digits=0x00, running=0, alarm=0, wrap=0, tick=0.
- Start pulse, then 40 cycles -> tick high every 4th cycle; digits=0x10 after the 40th edge; running=1.
- Digits at 0x99 in RUN, next tick -> digits=0x00; wrap high exactly one cycle.
- alarm_en=1, alarm_val=0x05, start from 0x00 -> after the 20th edge alarm=1, digits=0x05, running=0, and digits hold 20 more cycles. Then start -> 0x06 four edges later, alarm=0.
- Stop while prescaler=2, idle 10 cycles, start -> digits unchanged during PAUSE; next tick 2 edges after re-entering RUN.
- clear and start in the same cycle during RUN at 0x37 -> IDLE, digits=0x00. reset_n low mid-RUN -> same result on that edge.
